mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_pkg.sv | 15 +
 rtl/mem_access.sv | 150 +++++++++++++++
 tb/tb_mem_access.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared instruction definitions for the memory-access stage.
// Holds the datapath/register/opcode widths and the opcode values that the
// memory stage decodes (loads and stores). All other opcodes are treated as
// non-memory operations whose execute result is written back unchanged.
package mem_access_pkg;

  localparam int unsigned LEN_REG     = 32;
  localparam int unsigned LEN_REGNO   = 4;
  localparam int unsigned LEN_OPECODE = 6;

  localparam logic [LEN_OPECODE-1:0] OPE_ADD = 6'h00;
  localparam logic [LEN_OPECODE-1:0] OPE_LD  = 6'h23;
  localparam logic [LEN_OPECODE-1:0] OPE_ST  = 6'h2b;

endpackage

// File: rtl/mem_access.sv
// Memory-access pipeline stage (single entry).
// Accepts one operation from execute, performs at most one data-bus
// transaction for loads/stores, then holds the result for writeback until
// writeback is not stalling.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   valid_i / stall_o    execute handshake (accepted when valid_i & !stall_o)
//   opecode, rd_regno    operation code and destination register
//   data_rd, data_o      store data, execute result (address for LD/ST)
//   valid_o / stall_i    writeback handshake
//   is_wb_o, wb_regno_o, wb_data_o, misalign_o  result for writeback
//   mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_ack_i, mem_rdata_i
//                        data bus
module mem_access #(
  parameter int unsigned LEN_REG     = mem_access_pkg::LEN_REG,
  parameter int unsigned LEN_REGNO   = mem_access_pkg::LEN_REGNO,
  parameter int unsigned LEN_OPECODE = mem_access_pkg::LEN_OPECODE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_i,
  output logic                   stall_o,
  input  logic [LEN_OPECODE-1:0] opecode,
  input  logic [LEN_REGNO-1:0]   rd_regno,
  input  logic [LEN_REG-1:0]     data_rd,
  input  logic [LEN_REG-1:0]     data_o,
  output logic                   valid_o,
  input  logic                   stall_i,
  output logic                   is_wb_o,
  output logic [LEN_REGNO-1:0]   wb_regno_o,
  output logic [LEN_REG-1:0]     wb_data_o,
  output logic                   misalign_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [LEN_REG-1:0]     mem_addr_o,
  output logic [LEN_REG-1:0]     mem_wdata_o,
  input  logic                   mem_ack_i,
  input  logic [LEN_REG-1:0]     mem_rdata_i
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBus  = 2'd1;
  localparam logic [1:0] StOut  = 2'd2;

  logic [1:0]           r_state, w_state;
  logic [LEN_REG-1:0]   r_addr, w_addr;
  logic [LEN_REG-1:0]   r_wdata, w_wdata;
  logic [LEN_REG-1:0]   r_wb_data, w_wb_data;
  logic [LEN_REGNO-1:0] r_regno, w_regno;
  logic                 r_we, w_we;
  logic                 r_is_wb, w_is_wb;
  logic                 r_misalign, w_misalign;

  logic w_is_ld, w_is_st, w_aligned, w_in_bus, w_in_out;

  assign w_is_ld   = (opecode == LEN_OPECODE'(mem_access_pkg::OPE_LD));
  assign w_is_st   = (opecode == LEN_OPECODE'(mem_access_pkg::OPE_ST));
  assign w_aligned = (data_o[1:0] == 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wb_data  <= '0;
      r_regno    <= '0;
      r_we       <= 1'b0;
      r_is_wb    <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_addr     <= w_addr;
      r_wdata    <= w_wdata;
      r_wb_data  <= w_wb_data;
      r_regno    <= w_regno;
      r_we       <= w_we;
      r_is_wb    <= w_is_wb;
      r_misalign <= w_misalign;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_addr     = r_addr;
    w_wdata    = r_wdata;
    w_wb_data  = r_wb_data;
    w_regno    = r_regno;
    w_we       = r_we;
    w_is_wb    = r_is_wb;
    w_misalign = r_misalign;
    case (r_state)
      StIdle: begin
        if (valid_i) begin
          w_regno = rd_regno;
          if (w_is_ld || w_is_st) begin
            if (w_aligned) begin
              w_state    = StBus;
              w_addr     = data_o;
              w_wdata    = data_rd;
              w_we       = w_is_st;
              // Remembers "this is a load" so completion knows to write back.
              w_is_wb    = w_is_ld;
              w_misalign = 1'b0;
              w_wb_data  = '0;
            end else begin
              // Misaligned access is reported without touching the bus.
              w_state    = StOut;
              w_misalign = 1'b1;
              w_is_wb    = 1'b0;
              w_wb_data  = '0;
            end
          end else begin
            w_state    = StOut;
            w_wb_data  = data_o;
            w_is_wb    = 1'b1;
            w_misalign = 1'b0;
          end
        end
      end
      StBus: begin
        if (mem_ack_i) begin
          w_state   = StOut;
          w_wb_data = r_we ? '0 : mem_rdata_i;
        end
      end
      StOut: begin
        if (!stall_i) begin
          w_state = StIdle;
        end
      end
      default: w_state = StIdle;
    endcase
  end

  // Outputs are gated by state so every output reads 0 while idle or in reset.
  assign w_in_bus = (r_state == StBus);
  assign w_in_out = (r_state == StOut);

  assign stall_o     = (r_state != StIdle);
  assign valid_o     = w_in_out;
  assign is_wb_o     = w_in_out & r_is_wb;
  assign misalign_o  = w_in_out & r_misalign;
  assign wb_regno_o  = w_in_out ? r_regno : '0;
  assign wb_data_o   = w_in_out ? r_wb_data : '0;
  assign mem_req_o   = w_in_bus;
  assign mem_we_o    = w_in_bus & r_we;
  assign mem_addr_o  = w_in_bus ? r_addr : '0;
  assign mem_wdata_o = w_in_bus ? r_wdata : '0;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios followed by random
// operations, each compared against a rule-level reference model.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_i = 1'b0;
  logic        stall_o;
  logic [5:0]  opecode = '0;
  logic [3:0]  rd_regno = '0;
  logic [31:0] data_rd = '0;
  logic [31:0] data_o = '0;
  logic        valid_o;
  logic        stall_i = 1'b0;
  logic        is_wb_o;
  logic [3:0]  wb_regno_o;
  logic [31:0] wb_data_o;
  logic        misalign_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        is_st;
    logic        bus;
    logic        misalign;
    logic        is_wb;
    logic [31:0] wb_data;
  } exp_t;

  mem_access dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .stall_o    (stall_o),
    .opecode    (opecode),
    .rd_regno   (rd_regno),
    .data_rd    (data_rd),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .stall_i    (stall_i),
    .is_wb_o    (is_wb_o),
    .wb_regno_o (wb_regno_o),
    .wb_data_o  (wb_data_o),
    .misalign_o (misalign_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // What the stage must report for one operation, from the rules alone.
  function automatic exp_t model(input logic [5:0] opc, input logic [31:0] res,
                                 input logic [31:0] rdata);
    exp_t e;
    logic is_mem;
    is_mem     = (opc == OPE_LD) || (opc == OPE_ST);
    e.is_st    = (opc == OPE_ST);
    e.misalign = is_mem && ((res % 4) != 0);
    e.bus      = is_mem && !e.misalign;
    if (!is_mem) begin
      e.wb_data = res;
      e.is_wb   = 1'b1;
    end else if (e.bus && !e.is_st) begin
      e.wb_data = rdata;
      e.is_wb   = 1'b1;
    end else begin
      e.wb_data = '0;
      e.is_wb   = 1'b0;
    end
    return e;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "/stall_o"}, 32'(stall_o), 32'd0);
    chk({tag, "/valid_o"}, 32'(valid_o), 32'd0);
    chk({tag, "/is_wb_o"}, 32'(is_wb_o), 32'd0);
    chk({tag, "/wb_regno_o"}, 32'(wb_regno_o), 32'd0);
    chk({tag, "/wb_data_o"}, wb_data_o, 32'd0);
    chk({tag, "/misalign_o"}, 32'(misalign_o), 32'd0);
    chk({tag, "/mem_req_o"}, 32'(mem_req_o), 32'd0);
    chk({tag, "/mem_we_o"}, 32'(mem_we_o), 32'd0);
    chk({tag, "/mem_addr_o"}, mem_addr_o, 32'd0);
    chk({tag, "/mem_wdata_o"}, mem_wdata_o, 32'd0);
  endtask

  // Called right after a falling edge with the stage idle; returns likewise.
  task automatic run_op(input string tag, input logic [5:0] opc, input logic [3:0] regno,
                        input logic [31:0] res, input logic [31:0] sdata, input int waits,
                        input logic [31:0] rdata, input int stalls);
    exp_t e;
    e = model(opc, res, rdata);
    chk({tag, "/idle_stall_o"}, 32'(stall_o), 32'd0);
    valid_i  = 1'b1;
    opecode  = opc;
    rd_regno = regno;
    data_o   = res;
    data_rd  = sdata;
    @(posedge clk);
    #1;
    // Scramble the execute inputs: the stage must have latched what it needs.
    valid_i  = 1'b0;
    opecode  = 6'($urandom);
    rd_regno = 4'($urandom);
    data_o   = $urandom;
    data_rd  = $urandom;
    if (e.bus) begin
      for (int k = 0; k <= waits; k++) begin
        mem_ack_i   = (k == waits);
        mem_rdata_i = (k == waits) ? rdata : $urandom;
        @(negedge clk);
        chk({tag, "/bus_req"}, 32'(mem_req_o), 32'd1);
        chk({tag, "/bus_we"}, 32'(mem_we_o), 32'(e.is_st));
        chk({tag, "/bus_addr"}, mem_addr_o, res);
        if (e.is_st) chk({tag, "/bus_wdata"}, mem_wdata_o, sdata);
        chk({tag, "/bus_stall_o"}, 32'(stall_o), 32'd1);
        chk({tag, "/bus_valid_o"}, 32'(valid_o), 32'd0);
        @(posedge clk);
        #1;
      end
    end
    for (int s = 0; s <= stalls; s++) begin
      stall_i     = (s < stalls);
      valid_i     = 1'($urandom_range(0, 1));
      opecode     = 6'($urandom);
      data_o      = $urandom;
      mem_ack_i   = 1'($urandom_range(0, 1));
      mem_rdata_i = $urandom;
      @(negedge clk);
      chk({tag, "/out_valid_o"}, 32'(valid_o), 32'd1);
      chk({tag, "/out_stall_o"}, 32'(stall_o), 32'd1);
      chk({tag, "/out_mem_req_o"}, 32'(mem_req_o), 32'd0);
      chk({tag, "/out_wb_regno_o"}, 32'(wb_regno_o), 32'(regno));
      chk({tag, "/out_wb_data_o"}, wb_data_o, e.wb_data);
      chk({tag, "/out_is_wb_o"}, 32'(is_wb_o), 32'(e.is_wb));
      chk({tag, "/out_misalign_o"}, 32'(misalign_o), 32'(e.misalign));
      @(posedge clk);
      #1;
    end
    valid_i   = 1'b0;
    stall_i   = 1'b0;
    mem_ack_i = 1'b0;
    @(negedge clk);
    chk({tag, "/after_valid_o"}, 32'(valid_o), 32'd0);
    chk({tag, "/after_stall_o"}, 32'(stall_o), 32'd0);
    chk({tag, "/after_mem_req_o"}, 32'(mem_req_o), 32'd0);
  endtask

  function automatic logic [5:0] rand_nonmem();
    logic [5:0] op;
    op = 6'($urandom);
    while (op == OPE_LD || op == OPE_ST) op = 6'($urandom);
    return op;
  endfunction

  initial begin
    logic [5:0]  opc;
    logic [31:0] addr;
    int          sel;

    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_op("add_r3", OPE_ADD, 4'd3, 32'h0000_0005, 32'h0, 0, 32'h0, 0);
    run_op("ld_wait3", OPE_LD, 4'd7, 32'h0000_0100, 32'h0, 3, 32'hDEAD_BEEF, 0);
    run_op("st_imm", OPE_ST, 4'd2, 32'h0000_0104, 32'h0000_1234, 0, 32'h0, 0);
    run_op("ld_misalign", OPE_LD, 4'd5, 32'h0000_0102, 32'h0, 0, 32'h0, 0);
    run_op("st_misalign", OPE_ST, 4'd9, 32'h0000_0107, 32'hCAFE_F00D, 0, 32'h0, 0);
    run_op("add_stall5", OPE_ADD, 4'd12, 32'hA5A5_0F0F, 32'h0, 0, 32'h0, 5);
    run_op("ld_stall3", OPE_LD, 4'd15, 32'hFFFF_FFFC, 32'h0, 1, 32'h0BAD_F00D, 3);

    // Reset in the middle of a bus wait, then a late ack.
    valid_i  = 1'b1;
    opecode  = OPE_LD;
    rd_regno = 4'd4;
    data_o   = 32'h0000_0200;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    @(negedge clk);
    chk("rst_mid/req_before", 32'(mem_req_o), 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h1357_9BDF;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk_all_zero("late_ack");
    mem_ack_i = 1'b0;
    run_op("post_rst_add", OPE_ADD, 4'd1, 32'h0000_0042, 32'h0, 0, 32'h0, 0);

    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 2));
      opc = (sel == 0) ? OPE_LD : (sel == 1) ? OPE_ST : rand_nonmem();
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      run_op("rand", opc, 4'($urandom), addr, $urandom, int'($urandom_range(0, 4)),
             $urandom, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
